cpu_clock_sequencer: RTL

CPU_CLOCK_SEQUENCER -- requirements
Module: cpu_clock_sequencer

---
 rtl/cpu_clock_sequencer.sv | 101 ++++++++++
 1 files changed

// File: rtl/cpu_clock_sequencer.sv
// Paces a four-phase CPU pipeline with a programmable clock divider and
// sequences free-run, single-step and drain-to-boundary execution.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | stopped at an instruction boundary, divider held at 0
//   S_RUN   | free-running, ticking every div+1 clocks
//   S_STEP  | executing exactly one instruction, then back to idle
//   S_DRAIN | run dropped or halt raised; finishing current instruction
module cpu_clock_sequencer #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] div,
  input  logic             run,
  input  logic             step,
  input  logic             halt,
  output logic             tick,
  output logic [1:0]       phase,
  output logic             instr_done,
  output logic             busy,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP, S_DRAIN} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [1:0]       phase_q, phase_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             busy_q;
  logic             step_lo_q;
  logic             step_edge_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      phase_q     <= 2'd0;
      retired_q   <= '0;
      busy_q      <= 1'b0;
      step_lo_q   <= 1'b0;
      step_edge_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      retired_q   <= retired_d;
      busy_q      <= (state_d != S_IDLE);
      // step_lo_q only sets once step has been seen low, so a level held
      // high through reset release never looks like a new request
      step_lo_q   <= ~step;
      step_edge_q <= step & step_lo_q;
    end
  end

  always_comb begin
    tick       = 1'b0;
    instr_done = 1'b0;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    retired_d  = retired_q;
    state_d    = state_q;

    // >= rather than == so a shrinking div never strands the counter
    if (state_q != S_IDLE && cnt_q >= div) tick = 1'b1;
    instr_done = tick && (phase_q == 2'd3);

    if (state_q == S_IDLE || tick) cnt_d = '0;
    else                           cnt_d = cnt_q + DIV_W'(1);

    if (tick)       phase_d   = phase_q + 2'd1;
    if (instr_done) retired_d = retired_q + CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        if (!halt && run)              state_d = S_RUN;
        else if (!halt && step_edge_q) state_d = S_STEP;
      end
      S_RUN: begin
        // stopping exactly at a boundary skips DRAIN so no extra instruction runs
        if (!run || halt) state_d = instr_done ? S_IDLE : S_DRAIN;
      end
      S_STEP: begin
        if (instr_done) state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (run && !halt)    state_d = S_RUN;
        else if (instr_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign phase   = phase_q;
  assign busy    = busy_q;
  assign retired = retired_q;

endmodule
